// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB first,
// with carry/borrow chaining and signed-overflow flag behind a start/done handshake.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             mode_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [DIGIT-1:0] dsum;
    logic             dc_out;
    logic             dc_msb;
    logic [WIDTH-1:0] acc_next;

    // Subtraction runs as a + ~b + ~cin; the borrow is the inverted final carry.
    always_comb begin
        da = a_q[DIGIT-1:0];
        db = b_q[DIGIT-1:0] ^ {DIGIT{mode_q}};
        {dc_out, dsum} = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of this digit, recovered from its sum bit.
        dc_msb = dsum[DIGIT-1] ^ da[DIGIT-1] ^ db[DIGIT-1];
        acc_next = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        mode_q  <= mode;
                        carry_q <= cin ^ mode;
                        cnt_q   <= CW'(N);
                        busy    <= 1'b1;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_next;
                    carry_q <= dc_out;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result <= acc_next;
                        cout   <= dc_out ^ mode_q;
                        ovf    <= dc_out ^ dc_msb;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: three instances (1x1, 8x1, 8x4) sharing clock and reset.
module tb_serial_addsub;

  logic clk;
  logic rst_n;

  logic       s1_start, s1_mode, s1_cin, s1_busy, s1_done, s1_cout, s1_ovf;
  logic [0:0] s1_a, s1_b, s1_res;

  logic       s2_start, s2_mode, s2_cin, s2_busy, s2_done, s2_cout, s2_ovf;
  logic [7:0] s2_a, s2_b, s2_res;

  logic       s3_start, s3_mode, s3_cin, s3_busy, s3_done, s3_cout, s3_ovf;
  logic [7:0] s3_a, s3_b, s3_res;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .mode(s1_mode), .a(s1_a), .b(s1_b),
    .cin(s1_cin), .busy(s1_busy), .done(s1_done), .result(s1_res), .cout(s1_cout),
    .ovf(s1_ovf)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .mode(s2_mode), .a(s2_a), .b(s2_b),
    .cin(s2_cin), .busy(s2_busy), .done(s2_done), .result(s2_res), .cout(s2_cout),
    .ovf(s2_ovf)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .mode(s3_mode), .a(s3_a), .b(s3_b),
    .cin(s3_cin), .busy(s3_busy), .done(s3_done), .result(s3_res), .cout(s3_cout),
    .ovf(s3_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, cout, result} from plain integer arithmetic.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic mode);
    int ua, ub, sa, sb, ci, u, s;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(cin);
    if (!mode) begin
      u = ua + ub + ci;
      s = sa + sb + ci;
      c = (u > 255);
    end else begin
      u = ua - ub - ci;
      s = sa - sb - ci;
      c = (u < 0);
    end
    o = (s > 127) || (s < -128);
    return {o, c, u[7:0]};
  endfunction

  task automatic op1(input logic a, input logic b, input logic cin, input logic mode);
    int s;
    s1_a = a; s1_b = b; s1_cin = cin; s1_mode = mode; s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    chk("w1 busy after accept", s1_busy === 1'b1);
    tick();
    s = mode ? int'(a) - int'(b) - int'(cin) : int'(a) + int'(b) + int'(cin);
    chk("w1 done", s1_done === 1'b1);
    chk("w1 busy clear", s1_busy === 1'b0);
    chk("w1 result", s1_res[0] === s[0]);
    chk("w1 cout", s1_cout === (mode ? (s < 0) : s[1]));
  endtask

  task automatic wait_done2(output int n);
    n = 0;
    while (!s2_done && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic op2(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic mode, input logic [7:0] er,
                     input logic ec, input logic eo);
    int n;
    s2_a = a; s2_b = b; s2_cin = cin; s2_mode = mode; s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    chk({tag, " busy"}, s2_busy === 1'b1);
    wait_done2(n);
    chk({tag, " latency"}, n == 8);
    chk({tag, " result"}, s2_res === er);
    chk({tag, " cout"}, s2_cout === ec);
    chk({tag, " ovf"}, s2_ovf === eo);
    chk({tag, " busy clear"}, s2_busy === 1'b0);
    tick();
    chk({tag, " done width"}, s2_done === 1'b0);
  endtask

  initial begin
    logic [9:0] e;
    logic [9:0] expq[$];
    int acc_cycles[$];
    int n, dcount, prev_done, ndone;
    logic pre_busy;

    rst_n = 1'b0;
    s1_start = 0; s1_mode = 0; s1_cin = 0; s1_a = 0; s1_b = 0;
    s2_start = 0; s2_mode = 0; s2_cin = 0; s2_a = 0; s2_b = 0;
    s3_start = 0; s3_mode = 0; s3_cin = 0; s3_a = 0; s3_b = 0;
    #3;
    chk("reset busy", s2_busy === 1'b0);
    chk("reset done", s2_done === 1'b0);
    chk("reset result", s2_res === 8'h00);
    chk("reset cout", s2_cout === 1'b0);
    chk("reset ovf", s2_ovf === 1'b0);
    #9 rst_n = 1'b1;
    tick();

    // Full-adder / full-subtractor truth table
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      op1(v[0], v[1], v[2], v[3]);
    end
    tick();

    op2("add 5a+3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op2("add ff+00+1", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op2("add 5a+3c again", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);

    // Sub 10-20 with an ignored mid-run start; previous result must hold after accept
    s2_a = 8'h10; s2_b = 8'h20; s2_cin = 0; s2_mode = 1; s2_start = 1;
    tick();
    s2_start = 0;
    chk("hold result on accept", s2_res === 8'h96);
    tick(); tick();
    s2_a = 8'h77; s2_b = 8'h11; s2_mode = 0; s2_start = 1;
    tick(); tick();
    s2_start = 0;
    wait_done2(n);
    chk("sub 10-20 latency", n + 4 == 8);
    chk("sub 10-20 result", s2_res === 8'hF0);
    chk("sub 10-20 borrow", s2_cout === 1'b1);
    chk("sub 10-20 ovf", s2_ovf === 1'b0);
    tick();
    chk("busy start not queued", s2_busy === 1'b0);
    tick();
    chk("still idle", s2_busy === 1'b0);

    op2("sub 80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);

    // DIGIT=4: two-cycle latency, operand changes during run ignored
    s3_a = 8'hFF; s3_b = 8'h01; s3_cin = 0; s3_mode = 0; s3_start = 1;
    tick();
    s3_start = 0;
    chk("d4 busy", s3_busy === 1'b1);
    s3_a = 8'h00; s3_b = 8'h00;
    tick();
    chk("d4 no early done", s3_done === 1'b0);
    s3_a = 8'h55; s3_b = 8'hAA; s3_mode = 1; s3_cin = 1;
    tick();
    chk("d4 done", s3_done === 1'b1);
    chk("d4 result", s3_res === 8'h00);
    chk("d4 cout", s3_cout === 1'b1);
    chk("d4 ovf", s3_ovf === 1'b0);
    tick();

    // Back-to-back: start held high for 30 cycles with changing operands
    prev_done = 0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 30) begin
        s2_start = 1;
        s2_a = 8'($urandom);
        s2_b = 8'($urandom);
        s2_cin = 1'($urandom_range(0, 1));
        s2_mode = 1'($urandom_range(0, 1));
      end else begin
        s2_start = 0;
      end
      pre_busy = s2_busy;
      if (s2_start && !pre_busy) begin
        expq.push_back(model8(s2_a, s2_b, s2_cin, s2_mode));
        acc_cycles.push_back(c);
      end
      tick();
      if (s2_done) begin
        ndone++;
        chk("stream done width", prev_done == 0);
        chk("stream done expected", expq.size() > 0);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("stream result", s2_res === e[7:0]);
          chk("stream cout", s2_cout === e[8]);
          chk("stream ovf", s2_ovf === e[9]);
        end
      end
      prev_done = int'(s2_done);
    end
    chk("stream accepts", acc_cycles.size() == 4);
    chk("stream dones", ndone == 4);
    chk("stream drained", expq.size() == 0);
    for (int i = 1; i < acc_cycles.size(); i++)
      chk("stream accept spacing", acc_cycles[i] - acc_cycles[i-1] == 9);

    // Abort after 3 digits with asynchronous reset
    s2_a = 8'h12; s2_b = 8'h34; s2_cin = 0; s2_mode = 0; s2_start = 1;
    tick();
    s2_start = 0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", s2_busy === 1'b0);
    chk("abort done", s2_done === 1'b0);
    chk("abort result", s2_res === 8'h00);
    chk("abort cout", s2_cout === 1'b0);
    chk("abort ovf", s2_ovf === 1'b0);
    tick();
    #2 rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s2_done) dcount++;
    end
    chk("abort no done", dcount == 0);
    chk("abort idle", s2_busy === 1'b0);

    op2("sub 00-00-1", 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
